parking_gate_arbiter: RTL

// - Shares the single parking-slot FIFO among N_GATES entry gates and N_GATES exit gates.
// - Edge-detects and latches gate requests, then picks one per slot: round-robin within a

---
 rtl/parking_pkg.sv | 20 ++
 rtl/parking_gate_arbiter_rr_pick.sv | 29 ++
 rtl/parking_gate_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared encodings and defaults for the parking gate arbiter.
// State and class enums are used by the top and the bench.
package parking_pkg;

  localparam int N_GATES_DEF  = 4;
  localparam int CAPACITY_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    REJ   = 2'd3
  } state_e;

  typedef enum logic {
    CLS_ENTRY = 1'b0,
    CLS_EXIT  = 1'b1
  } cls_e;

endpackage

// File: rtl/parking_gate_arbiter_rr_pick.sv
// Round-robin picker: first pending index at or after ptr+1,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [W-1:0] jj;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    jj  = '0;
    for (int k = N; k >= 1; k--) begin
      jj = W'((int'(ptr) + k) % N);
      if (pending[jj]) begin
        any = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates entry/exit gate requests onto one slot FIFO.
// Edge-latched requests, per-class round-robin, class alternation.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int N_GATES  = N_GATES_DEF,
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int GATE_W   = $clog2(N_GATES),
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_GATES-1:0] entry_req,
  input  logic [N_GATES-1:0] exit_req,
  input  logic               is_full,
  input  logic               is_empty,
  output logic               write_enable,
  output logic               read_enable,
  output logic [GATE_W-1:0]  gate_id,
  output logic [N_GATES-1:0] entry_ack,
  output logic [N_GATES-1:0] exit_ack,
  output logic [N_GATES-1:0] entry_reject,
  output logic [N_GATES-1:0] exit_reject,
  output logic [CNT_W-1:0]   occupancy,
  output logic               busy
);

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   ent_ptr_q, ent_ptr_d;
  logic [GATE_W-1:0]   ext_ptr_q, ext_ptr_d;
  logic [N_GATES-1:0]  ent_prev_q, ext_prev_q;
  logic [N_GATES-1:0]  ent_pend_q, ent_pend_d;
  logic [N_GATES-1:0]  ext_pend_q, ext_pend_d;
  logic [N_GATES-1:0]  ent_clr, ext_clr, oh_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic                we_q, re_q, busy_q, busy_d;
  logic [N_GATES-1:0]  eack_q, xack_q, erej_q, xrej_q;
  logic                ent_any, ext_any, take_ent;
  logic [GATE_W-1:0]   ent_idx, ext_idx;

  rr_pick #(.N(N_GATES), .W(GATE_W)) u_ent_pick (
    .pending (ent_pend_q),
    .ptr     (ent_ptr_q),
    .any     (ent_any),
    .idx     (ent_idx)
  );

  rr_pick #(.N(N_GATES), .W(GATE_W)) u_ext_pick (
    .pending (ext_pend_q),
    .ptr     (ext_ptr_q),
    .any     (ext_any),
    .idx     (ext_idx)
  );

  assign take_ent = ent_any & (~ext_any | (cls_q == CLS_EXIT));

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    gate_d    = gate_q;
    ent_ptr_d = ent_ptr_q;
    ext_ptr_d = ext_ptr_q;
    ent_clr   = '0;
    ext_clr   = '0;
    unique case (state_q)
      IDLE: begin
        if (take_ent) begin
          gate_d           = ent_idx;
          ent_ptr_d        = ent_idx;
          ent_clr[ent_idx] = 1'b1;
          cls_d            = CLS_ENTRY;
          state_d          = is_full ? REJ : ENTRY;
        end else if (ext_any) begin
          gate_d           = ext_idx;
          ext_ptr_d        = ext_idx;
          ext_clr[ext_idx] = 1'b1;
          cls_d            = CLS_EXIT;
          state_d          = is_empty ? REJ : EXIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge in the clearing cycle is re-latched.
    ent_pend_d = (ent_pend_q & ~ent_clr) | (entry_req & ~ent_prev_q);
    ext_pend_d = (ext_pend_q & ~ext_clr) | (exit_req & ~ext_prev_q);
    oh_d       = N_GATES'(1) << gate_d;
    busy_d     = (|ent_pend_d) | (|ext_pend_d) | (state_d != IDLE);
  end

  always_comb begin
    occ_d = occ_q;
    if (we_q && occ_q != CNT_W'(CAPACITY)) begin
      occ_d = occ_q + 1'b1;
    end else if (re_q && occ_q != '0) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cls_q      <= CLS_EXIT;
      gate_q     <= '0;
      ent_ptr_q  <= '0;
      ext_ptr_q  <= '0;
      ent_prev_q <= '0;
      ext_prev_q <= '0;
      ent_pend_q <= '0;
      ext_pend_q <= '0;
      occ_q      <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      eack_q     <= '0;
      xack_q     <= '0;
      erej_q     <= '0;
      xrej_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      gate_q     <= gate_d;
      ent_ptr_q  <= ent_ptr_d;
      ext_ptr_q  <= ext_ptr_d;
      ent_prev_q <= entry_req;
      ext_prev_q <= exit_req;
      ent_pend_q <= ent_pend_d;
      ext_pend_q <= ext_pend_d;
      occ_q      <= occ_d;
      we_q       <= (state_d == ENTRY);
      re_q       <= (state_d == EXIT);
      eack_q     <= (state_d == ENTRY) ? oh_d : '0;
      xack_q     <= (state_d == EXIT) ? oh_d : '0;
      erej_q     <= (state_d == REJ && cls_d == CLS_ENTRY) ? oh_d : '0;
      xrej_q     <= (state_d == REJ && cls_d == CLS_EXIT) ? oh_d : '0;
      busy_q     <= busy_d;
    end
  end

  assign write_enable = we_q;
  assign read_enable  = re_q;
  assign gate_id      = gate_q;
  assign entry_ack    = eack_q;
  assign exit_ack     = xack_q;
  assign entry_reject = erej_q;
  assign exit_reject  = xrej_q;
  assign occupancy    = occ_q;
  assign busy         = busy_q;

endmodule
